// File: rtl/ms_wb_defs.sv
// rtl/ms_wb_defs.sv - shared Wishbone arbiter state encodings and error data
package ms_wb_defs;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT0  = 2'd1,
    ST_GNT1  = 2'd2,
    ST_ABORT = 2'd3
  } wb_arb_state_t;

  // Returned on aborted accesses and by the top-level decoder for unmapped reads
  localparam logic [31:0] WB_ERR_DATA = 32'hDEADBEEF;

  function automatic logic [1:0] gnt_decode(input wb_arb_state_t st);
    case (st)
      ST_GNT0: return 2'b01;
      ST_GNT1: return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ms_wb_watchdog.sv
// rtl/ms_wb_watchdog.sv - per-access stall counter for the Wishbone arbiter
module ms_wb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires one cycle before the abort so ABORT lands TIMEOUT cycles after stb rose
  assign expire = (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/ms_wb_arbiter2.sv
// rtl/ms_wb_arbiter2.sv - two-master round-robin Wishbone arbiter with watchdog abort
module ms_wb_arbiter2 #(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o,
  output logic              timeout_o
);

  import ms_wb_defs::*;

  wb_arb_state_t r_state;
  logic          r_last;
  logic          r_timeout;

  logic w_gnt0;
  logic w_gnt1;
  logic w_abort;
  logic w_idle;
  logic w_wd_clr;
  logic w_wd_run;
  logic w_expire;

  assign w_gnt0  = (r_state == ST_GNT0);
  assign w_gnt1  = (r_state == ST_GNT1);
  assign w_abort = (r_state == ST_ABORT);
  assign w_idle  = (r_state == ST_IDLE);

  // Control strobes only pass for the owner; address/data default to master 0
  assign s_cyc_o = (w_gnt0 & m0_cyc_i) | (w_gnt1 & m1_cyc_i);
  assign s_stb_o = (w_gnt0 & m0_stb_i) | (w_gnt1 & m1_stb_i);
  assign s_we_o  = (w_gnt0 & m0_we_i)  | (w_gnt1 & m1_we_i);
  assign s_sel_o = w_gnt1 ? m1_sel_i : m0_sel_i;
  assign s_adr_o = w_gnt1 ? m1_adr_i : m0_adr_i;
  assign s_dat_o = w_gnt1 ? m1_dat_i : m0_dat_i;

  // r_last names the owner of the access being aborted
  assign m0_ack_o = (w_gnt0 & s_ack_i) | (w_abort & ~r_last);
  assign m1_ack_o = (w_gnt1 & s_ack_i) | (w_abort &  r_last);
  assign m0_dat_o = (w_abort & ~r_last) ? DW'(WB_ERR_DATA) : s_dat_i;
  assign m1_dat_o = (w_abort &  r_last) ? DW'(WB_ERR_DATA) : s_dat_i;

  assign gnt_o     = gnt_decode(r_state);
  assign timeout_o = r_timeout;

  assign w_wd_clr = w_idle | ~s_stb_o | s_ack_i;
  assign w_wd_run = ~w_wd_clr;

  ms_wb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (w_wd_clr),
    .run    (w_wd_run),
    .expire (w_expire)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= ST_IDLE;
      r_last    <= 1'b1;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
            r_state <= ST_GNT0;
            r_last  <= 1'b0;
          end else if (m1_cyc_i) begin
            r_state <= ST_GNT1;
            r_last  <= 1'b1;
          end
        end
        ST_GNT0: begin
          if (!m0_cyc_i) begin
            r_state <= ST_IDLE;
          end else if (w_expire && !s_ack_i) begin
            r_state   <= ST_ABORT;
            r_timeout <= 1'b1;
          end
        end
        ST_GNT1: begin
          if (!m1_cyc_i) begin
            r_state <= ST_IDLE;
          end else if (w_expire && !s_ack_i) begin
            r_state   <= ST_ABORT;
            r_timeout <= 1'b1;
          end
        end
        ST_ABORT: r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ms_wb_arbiter2.sv
// tb/tb_ms_wb_arbiter2.sv - self-checking bench for the two-master Wishbone arbiter
module tb_ms_wb_arbiter2;

  localparam int TMO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        m0_cyc_i, m0_stb_i, m0_we_i;
  logic [3:0]  m0_sel_i;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic        m0_ack_o;
  logic        m1_cyc_i, m1_stb_i, m1_we_i;
  logic [3:0]  m1_sel_i;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic        m1_ack_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_ack_i;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  int total;
  int bad;
  int last;

  ms_wb_arbiter2 #(.TIMEOUT(TMO), .AW(32), .DW(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL global_time_limit observed=running expected=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // One arbitration round: selected masters raise cyc together from IDLE, each
  // holds until its access ends; the slave acks d cycles after stb rises, and
  // any d >= TMO means the slave never acks and the access must be aborted.
  task automatic run_round(input logic [1:0] mask, input int d0, input int d1);
    int          f, s, tend, own;
    int          g[2], e[2], d[2];
    bit          ab[2];
    logic [31:0] adr[2], wdat[2], rdat;
    logic [3:0]  sel[2];
    logic        we[2];
    logic        exp_stb, exp_tmo;
    logic [1:0]  exp_gnt;
    d[0] = d0;
    d[1] = d1;
    for (int i = 0; i < 2; i++) begin
      adr[i]  = $urandom;
      wdat[i] = $urandom;
      sel[i]  = 4'($urandom_range(0, 15));
      we[i]   = 1'($urandom_range(0, 1));
      g[i]    = -10;
      e[i]    = -10;
      ab[i]   = 1'b0;
    end
    if (mask == 2'b11) f = (last == 1) ? 0 : 1;
    else               f = mask[1] ? 1 : 0;
    s = 1 - f;
    g[f]  = 1;
    ab[f] = (d[f] >= TMO);
    e[f]  = g[f] + (ab[f] ? TMO : d[f]);
    last  = f;
    tend  = e[f];
    if (mask == 2'b11) begin
      g[s]  = ab[f] ? e[f] + 2 : e[f] + 3;
      ab[s] = (d[s] >= TMO);
      e[s]  = g[s] + (ab[s] ? TMO : d[s]);
      last  = s;
      tend  = e[s];
    end
    tend += 3;
    m0_adr_i = adr[0]; m0_dat_i = wdat[0]; m0_sel_i = sel[0]; m0_we_i = we[0];
    m1_adr_i = adr[1]; m1_dat_i = wdat[1]; m1_sel_i = sel[1]; m1_we_i = we[1];
    for (int t = 0; t <= tend; t++) begin
      m0_cyc_i = (t <= e[0]);
      m0_stb_i = (t <= e[0]);
      m1_cyc_i = (t <= e[1]);
      m1_stb_i = (t <= e[1]);
      s_ack_i  = (t == e[0] && !ab[0]) || (t == e[1] && !ab[1]);
      rdat     = $urandom;
      s_dat_i  = rdat;
      @(negedge clk_i);
      own     = -1;
      exp_stb = 1'b0;
      exp_tmo = 1'b0;
      for (int m = 0; m < 2; m++) begin
        if (t >= g[m] && t <= e[m] && !(ab[m] && t == e[m])) begin
          own     = m;
          exp_stb = 1'b1;
        end
        if (t == e[m] + 1 && !ab[m]) own = m;
        if (ab[m] && t == e[m]) exp_tmo = 1'b1;
      end
      exp_gnt = (own == 0) ? 2'b01 : (own == 1) ? 2'b10 : 2'b00;
      chk("round_gnt", 64'(gnt_o), 64'(exp_gnt));
      chk("round_s_stb", 64'(s_stb_o), 64'(exp_stb));
      chk("round_timeout", 64'(timeout_o), 64'(exp_tmo));
      chk("round_m0_ack", 64'(m0_ack_o), 64'(t == e[0]));
      chk("round_m1_ack", 64'(m1_ack_o), 64'(t == e[1]));
      for (int m = 0; m < 2; m++) begin
        if (t == e[m]) begin
          chk("round_m_dat", 64'(m == 0 ? m0_dat_o : m1_dat_o), 64'(ab[m] ? ERR : rdat));
          if (!ab[m]) begin
            chk("round_s_adr", 64'(s_adr_o), 64'(adr[m]));
            chk("round_s_dat", 64'(s_dat_o), 64'(wdat[m]));
            chk("round_s_sel", 64'(s_sel_o), 64'(sel[m]));
            chk("round_s_we", 64'(s_we_o), 64'(we[m]));
          end
        end
      end
      next_cycle();
    end
    s_ack_i = 1'b0;
  endtask

  initial begin
    logic [31:0] bdat, badr, rd;
    logic [3:0]  bsel;
    total = 0;
    bad   = 0;
    last  = 1;
    rst_i = 1'b1;
    m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_sel_i = 0; m0_adr_i = 0; m0_dat_i = 0;
    m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_sel_i = 0; m1_adr_i = 0; m1_dat_i = 0;
    s_dat_i = 0; s_ack_i = 0;
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    chk("rst_gnt", 64'(gnt_o), 64'd0);
    chk("rst_timeout", 64'(timeout_o), 64'd0);
    chk("rst_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rst_s_stb", 64'(s_stb_o), 64'd0);
    chk("rst_s_we", 64'(s_we_o), 64'd0);
    chk("rst_acks", 64'({m0_ack_o, m1_ack_o}), 64'd0);
    next_cycle();
    rst_i = 1'b0;

    run_round(2'b01, 2, 0);
    run_round(2'b11, 1, 3);
    run_round(2'b11, 0, 2);
    run_round(2'b01, 20, 0);
    run_round(2'b10, 7, 0);
    run_round(2'b11, 9, 7);

    // m1 burst of four writes while m0 waits
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1;
    @(negedge clk_i);
    chk("burst_t0_gnt", 64'(gnt_o), 64'd0);
    for (int b = 0; b < 4; b++) begin
      next_cycle();
      bdat = $urandom;
      bsel = 4'($urandom_range(0, 15));
      badr = 32'h3004_0000 + 32'(b * 4);
      m0_cyc_i = 1; m0_stb_i = 1; m0_we_i = 0;
      m1_dat_i = bdat; m1_sel_i = bsel; m1_adr_i = badr;
      s_ack_i = 1;
      @(negedge clk_i);
      chk("burst_gnt", 64'(gnt_o), 64'b10);
      chk("burst_s_dat", 64'(s_dat_o), 64'(bdat));
      chk("burst_s_sel", 64'(s_sel_o), 64'(bsel));
      chk("burst_s_adr", 64'(s_adr_o), 64'(badr));
      chk("burst_s_we", 64'(s_we_o), 64'd1);
      chk("burst_m1_ack", 64'(m1_ack_o), 64'd1);
      chk("burst_m0_ack", 64'(m0_ack_o), 64'd0);
    end
    next_cycle();
    m1_cyc_i = 0; m1_stb_i = 0;
    @(negedge clk_i);
    chk("burst_rel_gnt", 64'(gnt_o), 64'b10);
    chk("burst_rel_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("burst_rel_m0_ack", 64'(m0_ack_o), 64'd0);
    next_cycle();
    s_ack_i = 0;
    @(negedge clk_i);
    chk("burst_idle_gnt", 64'(gnt_o), 64'd0);
    chk("burst_idle_m0_ack", 64'(m0_ack_o), 64'd0);
    next_cycle();
    rd = $urandom;
    s_dat_i = rd;
    s_ack_i = 1;
    @(negedge clk_i);
    chk("after_burst_gnt", 64'(gnt_o), 64'b01);
    chk("after_burst_m0_ack", 64'(m0_ack_o), 64'd1);
    chk("after_burst_m0_dat", 64'(m0_dat_o), 64'(rd));
    next_cycle();
    m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
    @(negedge clk_i);
    chk("after_burst_hold", 64'(gnt_o), 64'b01);
    next_cycle();
    @(negedge clk_i);
    chk("after_burst_idle", 64'(gnt_o), 64'd0);
    last = 0;
    next_cycle();

    // reset while m1 owns the slave with stb pending
    m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0;
    next_cycle();
    @(negedge clk_i);
    chk("rstmid_gnt_before", 64'(gnt_o), 64'b10);
    next_cycle();
    next_cycle();
    rst_i = 1;
    next_cycle();
    s_ack_i = 1;
    @(negedge clk_i);
    chk("rstmid_s_cyc", 64'(s_cyc_o), 64'd0);
    chk("rstmid_gnt", 64'(gnt_o), 64'd0);
    chk("rstmid_acks", 64'({m0_ack_o, m1_ack_o}), 64'd0);
    chk("rstmid_timeout", 64'(timeout_o), 64'd0);
    next_cycle();
    rst_i = 0; m1_cyc_i = 0; m1_stb_i = 0; s_ack_i = 0;
    @(negedge clk_i);
    chk("rstmid_idle", 64'(gnt_o), 64'd0);
    last = 1;
    next_cycle();
    run_round(2'b11, 3, 3);

    for (int r = 0; r < 40; r++) begin
      run_round(2'($urandom_range(1, 3)), $urandom_range(0, 10), $urandom_range(0, 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
